coin_vend_ctrl: RTL

Sequential vending controller of the Lab4 coin machine. Accumulates inserted coins into a 4-bit credit register and drives product-select/credit into the credit-vs-price comparator. Consumes the comparator's `enough` result to dispense, then pays change one unit per cycle. Sits directly on both sides of the comparator: its `credit`/`sel` outputs feed it, and its `enough` input is the comparator's output.

---
 rtl/vend_pkg.sv | 62 ++++++
 rtl/vend_timeout_timer.sv | 31 +++
 rtl/coin_vend_ctrl.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/vend_pkg.sv
// Shared types and price/coin tables for the coin vending controller.
// Holds the state enum, coin codes, CREDIT_W and the lookup helpers.
package vend_pkg;

  localparam int CREDIT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CREDIT,
    ST_CHECK,
    ST_VEND,
    ST_CHANGE
  } state_e;

  typedef enum logic [1:0] {
    COIN_1  = 2'b00,
    COIN_2  = 2'b01,
    COIN_5  = 2'b10,
    COIN_10 = 2'b11
  } coin_e;

  localparam logic [CREDIT_W-1:0] PRICE_P1 = 4'd1;
  localparam logic [CREDIT_W-1:0] PRICE_P2 = 4'd4;
  localparam logic [CREDIT_W-1:0] PRICE_P3 = 4'd5;
  localparam logic [CREDIT_W-1:0] PRICE_P4 = 4'd7;

  // One extra bit so credit + coin can expose overflow.
  function automatic logic [CREDIT_W:0] coin_value(
    input coin_e c
  );
    logic [CREDIT_W:0] v;
    unique case (c)
      COIN_1:  v = 5'd1;
      COIN_2:  v = 5'd2;
      COIN_5:  v = 5'd5;
      COIN_10: v = 5'd10;
      default: v = 5'd0;
    endcase
    return v;
  endfunction

  function automatic logic [CREDIT_W-1:0] price_of(
    input logic [2:0] p
  );
    logic [CREDIT_W-1:0] v;
    case (p)
      3'd1:    v = PRICE_P1;
      3'd2:    v = PRICE_P2;
      3'd3:    v = PRICE_P3;
      3'd4:    v = PRICE_P4;
      default: v = '0;
    endcase
    return v;
  endfunction

  function automatic logic prod_valid(
    input logic [2:0] p
  );
    return (p >= 3'd1) && (p <= 3'd4);
  endfunction

endpackage

// File: rtl/vend_timeout_timer.sv
// Idle-cycle counter for the credit auto-refund.
// Ports: clk, rst_n, run_i (count this cycle, else clear), expired_o.
module vend_timeout_timer #(
  parameter int LIMIT = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run_i,
  output logic expired_o
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt_q, cnt_d;

  // Any non-counting cycle restarts the idle window.
  always_comb begin
    cnt_d = '0;
    if (run_i) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // Fires on the LIMIT-th consecutive idle cycle.
  assign expired_o = run_i &&
                     (cnt_q == W'(LIMIT - 1));

endmodule

// File: rtl/coin_vend_ctrl.sv
// Coin vending controller: credit accumulate, check, vend, change.
// Optional REFUND_TIMEOUT_EN macro adds an idle auto-refund in CREDIT.
// Ports: clk, rst_n, coin_valid/coin_val, product_req/product_sel,
//  cancel, enough (comparator) -> credit, sel, dispense,
//  dispensed_item, change_pulse, coin_reject, insufficient, busy.
module coin_vend_ctrl #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       coin_valid,
  input  logic [1:0] coin_val,
  input  logic       product_req,
  input  logic [2:0] product_sel,
  input  logic       cancel,
  input  logic       enough,
  output logic [3:0] credit,
  output logic [2:0] sel,
  output logic       dispense,
  output logic [2:0] dispensed_item,
  output logic       change_pulse,
  output logic       coin_reject,
  output logic       insufficient,
  output logic       busy
);

  import vend_pkg::*;

  state_e state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [2:0] prod_q, prod_d;
  logic [2:0] sel_q, sel_d;
  logic [2:0] item_q, item_d;
  logic disp_q, disp_d;
  logic chg_q, chg_d;
  logic rej_q, rej_d;
  logic insuf_q, insuf_d;
  logic coin_acc;
  logic coin_fits;
  logic expired;
  logic [CREDIT_W:0] sum;

  assign sum = {1'b0, credit_q} +
               coin_value(coin_e'(coin_val));
  assign coin_fits = coin_valid && !sum[CREDIT_W];

`ifdef REFUND_TIMEOUT_EN
  logic tmr_run;

  // An accepted coin restarts the idle window.
  assign tmr_run = (state_q == ST_CREDIT) &&
                   !coin_fits;

  vend_timeout_timer #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_tmr (
    .clk      (clk),
    .rst_n    (rst_n),
    .run_i    (tmr_run),
    .expired_o(expired)
  );
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES == 0);
  assign expired = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    prod_d   = prod_q;
    coin_acc = 1'b0;
    insuf_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (coin_valid) begin
          coin_acc = 1'b1;
          credit_d = sum[CREDIT_W-1:0];
          state_d  = ST_CREDIT;
        end
      end
      ST_CREDIT: begin
        if (cancel) begin
          state_d = ST_CHANGE;
        end else if (product_req &&
                     prod_valid(product_sel)) begin
          prod_d  = product_sel;
          state_d = ST_CHECK;
        end else if (coin_fits) begin
          coin_acc = 1'b1;
          credit_d = sum[CREDIT_W-1:0];
        end else if (expired) begin
          state_d = ST_CHANGE;
        end
      end
      ST_CHECK: begin
        if (enough) begin
          credit_d = credit_q - price_of(prod_q);
          state_d  = ST_VEND;
        end else begin
          insuf_d = 1'b1;
          state_d = ST_CREDIT;
        end
      end
      ST_VEND: begin
        state_d = (credit_q != '0) ? ST_CHANGE
                                   : ST_IDLE;
      end
      ST_CHANGE: begin
        if (credit_q <= 4'd1) begin
          credit_d = '0;
          state_d  = ST_IDLE;
        end else begin
          credit_d = credit_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered against the state being entered.
    rej_d  = coin_valid && !coin_acc;
    sel_d  = (state_d == ST_CHECK) ? prod_d : 3'd0;
    disp_d = (state_d == ST_VEND);
    item_d = (state_d == ST_VEND) ? prod_q : 3'd0;
    chg_d  = (state_d == ST_CHANGE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      credit_q <= '0;
      prod_q   <= '0;
      sel_q    <= '0;
      item_q   <= '0;
      disp_q   <= 1'b0;
      chg_q    <= 1'b0;
      rej_q    <= 1'b0;
      insuf_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      prod_q   <= prod_d;
      sel_q    <= sel_d;
      item_q   <= item_d;
      disp_q   <= disp_d;
      chg_q    <= chg_d;
      rej_q    <= rej_d;
      insuf_q  <= insuf_d;
    end
  end

  assign credit         = credit_q;
  assign sel            = sel_q;
  assign dispense       = disp_q;
  assign dispensed_item = item_q;
  assign change_pulse   = chg_q;
  assign coin_reject    = rej_q;
  assign insufficient   = insuf_q;
  assign busy = (state_q == ST_CHECK) ||
                (state_q == ST_VEND)  ||
                (state_q == ST_CHANGE);

endmodule
